// File: rtl/dcp_xbar_pkg.sv
// Shared types, widths and helpers for the decoupled tag crossbar.
// The payload width follows the system address width plus the fixed tag fields.
`ifndef ADDR_LENTH
`define ADDR_LENTH 5
`endif

package dcp_xbar_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int DEF_DW     = `ADDR_LENTH + 11;

    // Buffer entry layout at the default payload width (16 ports -> 4-bit source)
    typedef struct packed {
        logic [DEF_DW-1:0]      pld;
        logic [$clog2(16)-1:0]  src;
    } entry_t;

    function automatic logic [4:0] rr_next(input logic [4:0] ptr, input logic [4:0] n);
        return ((ptr + 5'd1) >= n) ? 5'd0 : (ptr + 5'd1);
    endfunction

endpackage

// File: rtl/dcp_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after iPtr,
// in circular order, wins. Nothing is granted while iEn is low.
module dcp_rr_arbiter #(
    parameter int  N  = 16,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  iReq,
    input  logic [IW-1:0] iPtr,
    input  logic          iEn,
    output logic [N-1:0]  oGnt,
    output logic [IW-1:0] oGntIdx
);

    int   bestDist_s;
    int   bestIdx_s;
    int   dist_s;
    logic take_s;

    // Pick the requester with the smallest circular distance from the pointer.
    always_comb begin
        bestDist_s = N;
        bestIdx_s  = 0;
        dist_s     = 0;
        take_s     = 1'b0;
        for (int i = 0; i < N; i++) begin
            dist_s     = (i >= int'(iPtr)) ? (i - int'(iPtr)) : (i + N - int'(iPtr));
            take_s     = iEn && iReq[i] && (dist_s < bestDist_s);
            bestDist_s = take_s ? dist_s : bestDist_s;
            bestIdx_s  = take_s ? i : bestIdx_s;
        end
        for (int i = 0; i < N; i++) begin
            oGnt[i] = (bestDist_s < N) && (bestIdx_s == i);
        end
        oGntIdx = IW'(bestIdx_s);
    end

endmodule

// File: rtl/dcp_tag_xbar_rr.sv
// NxN single-stage tag crossbar: per-output round-robin arbitration into a
// two-entry output buffer, source index returned with each tag, bad-Dst tags dropped and counted.
module dcp_tag_xbar_rr
    import dcp_xbar_pkg::*;
#(
    parameter int  NUM_PORTS = 16,
    parameter int  DW        = DEF_DW,
    parameter int  AW        = 4,
    localparam int SW        = $clog2(NUM_PORTS)
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic [NUM_PORTS-1:0]    iVld,
    input  logic [NUM_PORTS*DW-1:0] iPld,
    input  logic [NUM_PORTS*AW-1:0] iDst,
    output logic [NUM_PORTS-1:0]    iRdy,
    output logic [NUM_PORTS-1:0]    oVld,
    output logic [NUM_PORTS*DW-1:0] oPld,
    output logic [NUM_PORTS*SW-1:0] oSrc,
    input  logic [NUM_PORTS-1:0]    oRdy,
    output logic [DROP_CNT_W-1:0]   oDropCnt
);

    localparam int N  = NUM_PORTS;
    localparam int CW = DROP_CNT_W;

    typedef struct packed {
        logic [DW-1:0] pld;
        logic [SW-1:0] src;
    } bufEntry_t;

    logic [N-1:0]  reqMat_s [N];
    logic [N-1:0]  gntMat_s [N];
    logic [SW-1:0] gntIdx_s [N];
    logic [N-1:0]  gntEn_s;
    logic [N-1:0]  dropReq_s;
    logic [N-1:0]  push_s;
    logic [N-1:0]  pop_s;
    bufEntry_t     pushEnt_s [N];
    bufEntry_t     head_r [N];
    bufEntry_t     tail_r [N];
    bufEntry_t     headNxt_s [N];
    bufEntry_t     tailNxt_s [N];
    logic [N-1:0]  headVld_r;
    logic [N-1:0]  tailVld_r;
    logic [N-1:0]  headVldNxt_s;
    logic [N-1:0]  tailVldNxt_s;
    logic [SW-1:0] ptr_r [N];
    logic [SW-1:0] ptrNxt_s [N];
    logic [CW-1:0] dropCnt_r;
    logic [CW-1:0] dropCntNxt_s;
    logic [CW:0]   dropSum_s;

    // Transpose per-input destinations into per-output request vectors.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) begin
                reqMat_s[j][k] = iVld[k] && (iDst[k*AW +: AW] == AW'(j));
            end
        end
        for (int k = 0; k < N; k++) begin
            dropReq_s[k] = iVld[k] && (32'(iDst[k*AW +: AW]) >= 32'(N));
        end
        // A full buffer refuses grants even if it pops this cycle, keeping oRdy off the iRdy path
        gntEn_s = ~tailVld_r & {N{iRst_n}};
    end

    for (genvar j = 0; j < N; j++) begin : gArb
        dcp_rr_arbiter #(
            .N (N)
        ) uArb (
            .iReq    (reqMat_s[j]),
            .iPtr    (ptr_r[j]),
            .iEn     (gntEn_s[j]),
            .oGnt    (gntMat_s[j]),
            .oGntIdx (gntIdx_s[j])
        );
    end

    // Input accepts, the entry each output pushes, and the advanced RR pointer.
    always_comb begin
        iRdy = dropReq_s & {N{iRst_n}};
        for (int j = 0; j < N; j++) begin
            iRdy             = iRdy | gntMat_s[j];
            push_s[j]        = |gntMat_s[j];
            pop_s[j]         = headVld_r[j] & oRdy[j];
            pushEnt_s[j].pld = '0;
            for (int k = 0; k < N; k++) begin
                pushEnt_s[j].pld = pushEnt_s[j].pld | (iPld[k*DW +: DW] & {DW{gntMat_s[j][k]}});
            end
            pushEnt_s[j].src = gntIdx_s[j];
            ptrNxt_s[j]      = push_s[j] ? SW'(rr_next(5'(gntIdx_s[j]), 5'(N))) : ptr_r[j];
        end
    end

    // Two-entry output buffer: head drives the outputs, tail only fills behind a valid head.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            headNxt_s[j]    = head_r[j];
            tailNxt_s[j]    = tail_r[j];
            headVldNxt_s[j] = headVld_r[j];
            tailVldNxt_s[j] = tailVld_r[j];
            case ({push_s[j], pop_s[j]})
                2'b11: begin
                    headNxt_s[j] = pushEnt_s[j];
                end
                2'b10: begin
                    if (headVld_r[j]) begin
                        tailNxt_s[j]    = pushEnt_s[j];
                        tailVldNxt_s[j] = 1'b1;
                    end else begin
                        headNxt_s[j]    = pushEnt_s[j];
                        headVldNxt_s[j] = 1'b1;
                    end
                end
                2'b01: begin
                    headNxt_s[j]    = tail_r[j];
                    headVldNxt_s[j] = tailVld_r[j];
                    tailVldNxt_s[j] = 1'b0;
                end
                default: begin
                    headNxt_s[j] = head_r[j];
                end
            endcase
        end
    end

    // Saturating drop counter; several drops in one cycle add together.
    always_comb begin
        dropSum_s = {1'b0, dropCnt_r};
        for (int k = 0; k < N; k++) begin
            dropSum_s = dropSum_s + (CW+1)'(dropReq_s[k]);
        end
        if (dropSum_s[CW]) begin
            dropCntNxt_s = '1;
        end else begin
            dropCntNxt_s = dropSum_s[CW-1:0];
        end
    end

    // State registers; a reset discards every buffered tag.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            headVld_r <= '0;
            tailVld_r <= '0;
            dropCnt_r <= '0;
            for (int j = 0; j < N; j++) begin
                head_r[j] <= '0;
                tail_r[j] <= '0;
                ptr_r[j]  <= '0;
            end
        end else begin
            headVld_r <= headVldNxt_s;
            tailVld_r <= tailVldNxt_s;
            dropCnt_r <= dropCntNxt_s;
            for (int j = 0; j < N; j++) begin
                head_r[j] <= headNxt_s[j];
                tail_r[j] <= tailNxt_s[j];
                ptr_r[j]  <= ptrNxt_s[j];
            end
        end
    end

    assign oVld     = headVld_r;
    assign oDropCnt = dropCnt_r;

    for (genvar j = 0; j < N; j++) begin : gOut
        assign oPld[j*DW +: DW] = head_r[j].pld;
        assign oSrc[j*SW +: SW] = head_r[j].src;
    end

endmodule

// File: tb/tb_dcp_tag_xbar_rr.sv
// Bench for dcp_tag_xbar_rr: directed scenarios on a 16-port instance, then a
// queue-based reference model and a drop-saturation run on a 12-port instance.
module tb_dcp_tag_xbar_rr;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NA = 16;
    localparam int NB = 12;
    localparam int SWA = 4;
    localparam int SWB = 4;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic [NA-1:0]     aVld, aRdy, aOVld, aORdy;
    logic [NA*DW-1:0]  aPld, aOPld;
    logic [NA*AW-1:0]  aDst;
    logic [NA*SWA-1:0] aOSrc;
    logic [15:0]       aDrop;

    logic [NB-1:0]     bVld, bRdy, bOVld, bORdy;
    logic [NB*DW-1:0]  bPld, bOPld;
    logic [NB*AW-1:0]  bDst;
    logic [NB*SWB-1:0] bOSrc;
    logic [15:0]       bDrop;

    dcp_tag_xbar_rr #(.NUM_PORTS(NA), .DW(DW), .AW(AW)) uDutA (
        .iClk(clk), .iRst_n(rstN), .iVld(aVld), .iPld(aPld), .iDst(aDst), .iRdy(aRdy),
        .oVld(aOVld), .oPld(aOPld), .oSrc(aOSrc), .oRdy(aORdy), .oDropCnt(aDrop)
    );

    dcp_tag_xbar_rr #(.NUM_PORTS(NB), .DW(DW), .AW(AW)) uDutB (
        .iClk(clk), .iRst_n(rstN), .iVld(bVld), .iPld(bPld), .iDst(bDst), .iRdy(bRdy),
        .oVld(bOVld), .oPld(bOPld), .oSrc(bOSrc), .oRdy(bORdy), .oDropCnt(bDrop)
    );

    int nTotal = 0;
    int nBad = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setA(input int k, input logic v, input int dst, input int pld);
        aVld[k] = v;
        aDst[k*AW +: AW] = AW'(dst);
        aPld[k*DW +: DW] = DW'(pld);
    endtask

    // reference model state for the 12-port instance
    typedef struct {
        int pld;
        int src;
    } ent_t;
    ent_t mq [NB][$];
    int   mPtr [NB];
    int   mDrop;
    bit   hold [NB];
    int   hDst [NB];
    int   hPld [NB];
    int   gnt [NB];
    logic [NB-1:0] expRdy;
    logic [NB-1:0] expVld;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recv;
        int srcSeq [6];
        srcSeq = '{0, 5, 12, 0, 5, 12};
        aVld = '0; aPld = '0; aDst = '0; aORdy = '1;
        bVld = '0; bPld = '0; bDst = '0; bORdy = '1;

        // reset held with every input valid
        for (int k = 0; k < NA; k++) setA(k, 1'b1, k, k);
        for (int k = 0; k < NB; k++) begin
            bVld[k] = 1'b1;
            bDst[k*AW +: AW] = 4'd13;
        end
        #23;
        checkVal("rstRdyA", aRdy, 0);
        checkVal("rstVldA", aOVld, 0);
        checkVal("rstDropA", aDrop, 0);
        checkVal("rstRdyB", bRdy, 0);
        checkVal("rstDropB", bDrop, 0);
        @(posedge clk); #1;
        checkVal("rstDropB2", bDrop, 0);

        // single path in3 -> out9, visible one edge after release
        aVld = '0; bVld = '0;
        rstN = 1'b1;
        setA(3, 1'b1, 9, 'h155);
        #1;
        checkVal("pathRdy", aRdy, 16'h0008);
        tick();
        setA(3, 1'b0, 9, 'h155);
        checkVal("pathVld", aOVld, 16'h0200);
        checkVal("pathPld", aOPld[9*DW +: DW], 16'h0155);
        checkVal("pathSrc", aOSrc[9*SWA +: SWA], 3);
        tick();
        checkVal("pathEmpty", aOVld, 0);

        // fairness on output 2
        setA(0, 1'b1, 2, 'h100);
        setA(5, 1'b1, 2, 'h105);
        setA(12, 1'b1, 2, 'h10c);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkVal("rrVld", aOVld[2], 1);
            checkVal("rrSrc", aOSrc[2*SWA +: SWA], srcSeq[i]);
            checkVal("rrPld", aOPld[2*DW +: DW], 'h100 + srcSeq[i]);
        end
        aVld = '0;
        tick(); tick();
        checkVal("rrDrained", aOVld, 0);

        // backpressure on output 7
        aORdy[7] = 1'b0;
        sent = 0;
        for (int i = 0; i < 5; i++) begin
            setA(1, 1'b1, 7, 'h700 + sent);
            #1;
            if (aRdy[1]) sent++;
            tick();
        end
        setA(1, 1'b1, 7, 'h700 + sent);
        #1;
        checkVal("bpAccepts", sent, 2);
        checkVal("bpRdyLow", aRdy[1], 0);
        checkVal("bpHead", aOPld[7*DW +: DW], 'h700);
        aORdy[7] = 1'b1;
        recv = 0;
        for (int i = 0; i < 20; i++) begin
            if (recv == 4) break;
            setA(1, sent < 4, 7, 'h700 + sent);
            #1;
            if (aOVld[7]) begin
                checkVal("drainPld", aOPld[7*DW +: DW], 'h700 + recv);
                recv++;
            end
            if (sent < 4 && aRdy[1]) sent++;
            tick();
        end
        aVld = '0;
        checkVal("drainCnt", recv, 4);
        checkVal("drainEmpty", aOVld[7], 0);

        // fill eight buffers then reset mid-operation
        aORdy = '1;
        aORdy[7:0] = 8'h00;
        for (int k = 0; k < 8; k++) setA(k, 1'b1, k, 'h600 + k);
        tick(); tick(); tick();
        checkVal("fullVld", aOVld[7:0], 8'hFF);
        checkVal("fullRdy", aRdy[7:0], 8'h00);
        rstN = 1'b0;
        #1;
        checkVal("mrVld", aOVld, 0);
        checkVal("mrRdy", aRdy, 0);
        @(posedge clk); #1;
        aVld = '0;
        aORdy = '1;
        rstN = 1'b1;
        tick();
        checkVal("mrStale", aOVld, 0);
        setA(4, 1'b1, 5, 'h44);
        setA(6, 1'b1, 5, 'h66);
        #1;
        checkVal("mrPtr", aRdy, 16'h0010);
        tick();
        aVld = '0;
        checkVal("mrSrc", aOSrc[5*SWA +: SWA], 4);
        checkVal("mrPld", aOPld[5*DW +: DW], 'h44);

        // randomized traffic on the 12-port instance against the queue model
        mDrop = 0;
        for (int j = 0; j < NB; j++) begin
            mPtr[j] = 0;
            hold[j] = 1'b0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int k = 0; k < NB; k++) begin
                if (!hold[k] && $urandom_range(0, 9) < 7) begin
                    hold[k] = 1'b1;
                    if (cyc < 1000) hDst[k] = $urandom_range(0, 15);
                    else hDst[k] = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
                    hPld[k] = $urandom_range(0, 16'hFFFF);
                end
                bVld[k] = hold[k];
                bDst[k*AW +: AW] = AW'(hDst[k]);
                bPld[k*DW +: DW] = DW'(hPld[k]);
                bORdy[k] = (cyc < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            end
            #1;
            expRdy = '0;
            for (int j = 0; j < NB; j++) begin
                gnt[j] = -1;
                expVld[j] = (mq[j].size() > 0);
                if (mq[j].size() < 2) begin
                    for (int o = 0; o < NB; o++) begin
                        int k;
                        k = (mPtr[j] + o) % NB;
                        if (gnt[j] < 0 && hold[k] && hDst[k] == j) gnt[j] = k;
                    end
                end
                if (gnt[j] >= 0) expRdy[gnt[j]] = 1'b1;
            end
            for (int k = 0; k < NB; k++) begin
                if (hold[k] && hDst[k] >= NB) expRdy[k] = 1'b1;
            end
            checkVal("rndRdy", bRdy, expRdy);
            checkVal("rndVld", bOVld, expVld);
            checkVal("rndDrop", bDrop, mDrop);
            for (int j = 0; j < NB; j++) begin
                if (mq[j].size() > 0) begin
                    checkVal("rndOut", {bOPld[j*DW +: DW], bOSrc[j*SWB +: SWB]},
                             {DW'(mq[j][0].pld), SWB'(mq[j][0].src)});
                end
            end
            @(posedge clk);
            for (int j = 0; j < NB; j++) begin
                if (mq[j].size() > 0 && bORdy[j]) void'(mq[j].pop_front());
                if (gnt[j] >= 0) begin
                    ent_t e;
                    e.pld = hPld[gnt[j]];
                    e.src = gnt[j];
                    mq[j].push_back(e);
                    mPtr[j] = (gnt[j] + 1) % NB;
                end
            end
            for (int k = 0; k < NB; k++) begin
                if (hold[k] && hDst[k] >= NB) mDrop = (mDrop < 65535) ? mDrop + 1 : 65535;
                if (expRdy[k]) hold[k] = 1'b0;
            end
            #1;
        end

        // drop-counter saturation: every input targets a non-existent port
        bVld = '0;
        rstN = 1'b0;
        #1;
        checkVal("satRstDrop", bDrop, 0);
        checkVal("satRstVld", bOVld, 0);
        bVld = '1;
        bORdy = '1;
        for (int k = 0; k < NB; k++) bDst[k*AW +: AW] = 4'd13;
        @(posedge clk); #1;
        rstN = 1'b1;
        #1;
        checkVal("satRdy0", bRdy, 12'hFFF);
        for (int n = 1; n <= 5500; n++) begin
            tick();
            checkVal("satRdy", bRdy, 12'hFFF);
            checkVal("satVld", bOVld, 0);
            checkVal("satCnt", bDrop, (12 * n > 65535) ? 65535 : 12 * n);
        end

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
